ps2_kbd_cmd_ctrl: RTL and testbench

- Host-side command sequencer for the PS/2 keyboard.
- Accepts LED update requests from the MiniRISC slave bus and runs the keyboard "Set LEDs" exchange through the PS/2 byte transmitter: send 0xED, wait for ACK 0xFA, send LED byte, wait for ACK.
- Snoops the received-byte stream and claims ACK/RESEND bytes so they do not reach the keyboard ASCII FIFO.
- Handles resend, timeout and retry limit.

---
 rtl/ps2_kbd_cmd_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_ps2_kbd_cmd_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_cmd_ctrl.sv
// PS/2 keyboard host command sequencer: runs the "Set LEDs" (0xED + LED byte)
// exchange with ACK/RESEND handling, timeouts and a bounded retry count.
module ps2_kbd_cmd_ctrl #(
    parameter logic [7:0] BASEADDR       = 8'hff,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_mst2slv_addr,
    input  logic       s_mst2slv_wr,
    input  logic       s_mst2slv_rd,
    input  logic [7:0] s_mst2slv_data,
    output logic [7:0] s_slv2mst_data,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic       tx_done,
    input  logic       tx_err,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_consume,
    output logic       irq
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] KBD_ACK      = 8'hFA;
    localparam logic [7:0] KBD_RESEND   = 8'hFE;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        WAIT_TX1,
        WAIT_ACK1,
        SEND_LED,
        WAIT_TX2,
        WAIT_ACK2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      req_q, req_d;
    logic [2:0]      cur_q, cur_d;
    logic [2:0]      led_q, led_d;
    logic            ie_q, ie_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            pend_q, pend_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic [7:0] offset;
    logic       sel;
    logic       wr0;
    logic       wr1;
    logic       abort;
    logic       stclr;
    logic       led_wr;
    logic       busy;
    logic       timeout;
    logic       rx_ack;
    logic       rx_resend;
    logic       retry_req;
    state_t     retry_target;
    logic       unused_bits;

    // Two-register window: the offset from BASEADDR must be 0 or 1 (wraps mod 256).
    assign offset      = s_mst2slv_addr - BASEADDR;
    assign sel         = (offset[7:1] == 7'd0);
    assign wr0         = s_mst2slv_wr & sel & ~offset[0];
    assign wr1         = s_mst2slv_wr & sel & offset[0];
    assign abort       = wr0 & s_mst2slv_data[2];
    assign stclr       = wr0 & s_mst2slv_data[1];
    assign led_wr      = wr1 & ~abort;
    assign unused_bits = ^s_mst2slv_data[7:3];

    assign busy      = (state_q != IDLE);
    assign timeout   = (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign rx_ack    = rx_valid & (rx_data == KBD_ACK);
    assign rx_resend = rx_valid & (rx_data == KBD_RESEND);

    assign rx_consume = ((state_q == WAIT_ACK1) || (state_q == WAIT_ACK2)) &
                        (rx_ack | rx_resend);
    assign tx_start   = ~abort & ~tx_busy &
                        ((state_q == SEND_CMD) || (state_q == SEND_LED));
    assign irq        = ie_q & (done_q | err_q);

    always_comb begin
        tx_data = 8'h00;
        if (state_q == SEND_CMD) begin
            tx_data = CMD_SET_LEDS;
        end else if (state_q == SEND_LED) begin
            tx_data = {5'b00000, cur_q};
        end
    end

    always_comb begin
        s_slv2mst_data = 8'h00;
        if (s_mst2slv_rd && sel) begin
            if (offset[0]) begin
                s_slv2mst_data = {5'b00000, led_q};
            end else begin
                s_slv2mst_data = {busy, done_q, err_q, irq, pend_q, 2'b00, ie_q};
            end
        end
    end

    // Clears are applied before the FSM so a completion in the same cycle wins.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        cur_d        = cur_q;
        led_d        = led_q;
        ie_d         = ie_q;
        done_d       = done_q;
        err_d        = err_q;
        pend_d       = pend_q;
        retry_d      = retry_q;
        timer_d      = timer_q;
        retry_req    = 1'b0;
        retry_target = SEND_CMD;

        if (wr0) begin
            ie_d = s_mst2slv_data[0];
        end
        if (stclr || led_wr) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (led_wr) begin
            req_d = s_mst2slv_data[2:0];
        end

        if (abort) begin
            state_d = IDLE;
            pend_d  = 1'b0;
        end else begin
            if (led_wr && busy) begin
                pend_d = 1'b1;
            end
            case (state_q)
                IDLE: begin
                    retry_d = '0;
                    if (led_wr || pend_q) begin
                        state_d = SEND_CMD;
                        pend_d  = 1'b0;
                        cur_d   = led_wr ? s_mst2slv_data[2:0] : req_q;
                    end
                end
                SEND_CMD: begin
                    if (!tx_busy) begin
                        state_d = WAIT_TX1;
                        timer_d = '0;
                    end
                end
                WAIT_TX1: begin
                    timer_d = timer_q + 1'b1;
                    if (tx_done) begin
                        state_d = WAIT_ACK1;
                        timer_d = '0;
                    end else if (tx_err || timeout) begin
                        retry_req    = 1'b1;
                        retry_target = SEND_CMD;
                    end
                end
                WAIT_ACK1: begin
                    timer_d = timer_q + 1'b1;
                    if (rx_ack) begin
                        state_d = SEND_LED;
                    end else if (rx_resend || timeout) begin
                        retry_req    = 1'b1;
                        retry_target = SEND_CMD;
                    end
                end
                SEND_LED: begin
                    if (!tx_busy) begin
                        state_d = WAIT_TX2;
                        timer_d = '0;
                    end
                end
                WAIT_TX2: begin
                    timer_d = timer_q + 1'b1;
                    if (tx_done) begin
                        state_d = WAIT_ACK2;
                        timer_d = '0;
                    end else if (tx_err || timeout) begin
                        retry_req    = 1'b1;
                        retry_target = SEND_LED;
                    end
                end
                WAIT_ACK2: begin
                    timer_d = timer_q + 1'b1;
                    if (rx_ack) begin
                        led_d   = cur_q;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (rx_resend || timeout) begin
                        retry_req    = 1'b1;
                        retry_target = SEND_LED;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // A resend within a phase only repeats that phase's byte.
            if (retry_req) begin
                if (retry_q < RW'(MAX_RETRY)) begin
                    retry_d = retry_q + 1'b1;
                    state_d = retry_target;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 3'b000;
            cur_q   <= 3'b000;
            led_q   <= 3'b000;
            ie_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            retry_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cur_q   <= cur_d;
            led_q   <= led_d;
            ie_q    <= ie_d;
            done_q  <= done_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            retry_q <= retry_d;
            timer_q <= timer_d;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_cmd_ctrl.sv
// Directed self-checking bench for ps2_kbd_cmd_ctrl: LED exchange, resend,
// timeout retries, PEND handling, reset and abort.
module tb_ps2_kbd_cmd_ctrl;

   localparam logic [7:0] REG0 = 8'h20;
   localparam logic [7:0] REG1 = 8'h21;
   localparam int TMO = 100;

   logic       clock;
   logic       rst;
   logic [7:0] busAddr;
   logic       busWr;
   logic       busRd;
   logic [7:0] busWData;
   logic [7:0] busRData;
   logic [7:0] txData;
   logic       txStart;
   logic       txBusy;
   logic       txDone;
   logic       txErr;
   logic [7:0] rxData;
   logic       rxValid;
   logic       rxConsume;
   logic       irqOut;

   int vectors = 0;
   int miscompares = 0;
   int txCount = 0;
   int cycleCount = 0;
   int txTimes[$];
   logic [7:0] lastTxData = 8'h00;
   int edCount = 0;

   ps2_kbd_cmd_ctrl #(
      .BASEADDR(8'h20),
      .TIMEOUT_CYCLES(TMO),
      .MAX_RETRY(3)
   ) dut (
      .clk(clock),
      .rst(rst),
      .s_mst2slv_addr(busAddr),
      .s_mst2slv_wr(busWr),
      .s_mst2slv_rd(busRd),
      .s_mst2slv_data(busWData),
      .s_slv2mst_data(busRData),
      .tx_data(txData),
      .tx_start(txStart),
      .tx_busy(txBusy),
      .tx_done(txDone),
      .tx_err(txErr),
      .rx_data(rxData),
      .rx_valid(rxValid),
      .rx_consume(rxConsume),
      .irq(irqOut)
   );

   // Free-running clock with a 10 ns period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Cycle counter used to time-stamp transmit requests.
   always @(posedge clock) cycleCount++;

   // Records every transmit request seen mid-cycle.
   always @(negedge clock) begin
      if (txStart === 1'b1) begin
         txCount++;
         lastTxData = txData;
         txTimes.push_back(cycleCount);
         if (txData == 8'hED) edCount++;
      end
   end

   // Compares one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advances to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One-cycle bus register write.
   task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data);
      busAddr  = addr;
      busWData = data;
      busWr    = 1'b1;
      tick();
      busWr    = 1'b0;
   endtask

   // Combinational bus read sampled inside the current cycle.
   task automatic busRead(input logic [7:0] addr, output logic [7:0] data);
      busAddr = addr;
      busRd   = 1'b1;
      #1;
      data    = busRData;
      busRd   = 1'b0;
   endtask

   task automatic pulseTxDone();
      txDone = 1'b1;
      tick();
      txDone = 1'b0;
   endtask

   // Presents one received byte for a cycle and returns the claim flag.
   task automatic rxByte(input logic [7:0] b, output logic consumed);
      rxData   = b;
      rxValid  = 1'b1;
      #1;
      consumed = rxConsume;
      tick();
      rxValid  = 1'b0;
   endtask

   initial begin
      logic [7:0] rd;
      logic       c;
      int         base;
      int         tbase;
      logic       finished;

      rst      = 1'b1;
      busAddr  = 8'h00;
      busWr    = 1'b0;
      busRd    = 1'b0;
      busWData = 8'h00;
      txBusy   = 1'b0;
      txDone   = 1'b0;
      txErr    = 1'b0;
      rxData   = 8'h00;
      rxValid  = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      rst = 1'b0;
      tick();

      $display("[TB] reset state");
      checkOutput("rst_tx_start", txStart, 1'b0);
      checkOutput("rst_irq", irqOut, 1'b0);
      busRead(REG0, rd);
      checkOutput("rst_reg0", rd, 8'h00);
      busRead(REG1, rd);
      checkOutput("rst_reg1", rd, 8'h00);

      $display("[TB] basic set-LEDs exchange");
      applyStimulus(REG1, 8'h05);
      checkOutput("t1_start_latency", txStart, 1'b1);
      checkOutput("t1_cmd_byte", txData, 8'hED);
      tick();
      checkOutput("t1_start_one_cycle", txStart, 1'b0);
      busRead(REG0, rd);
      checkOutput("t1_busy", rd, 8'h80);
      pulseTxDone();
      rxByte(8'hFA, c);
      checkOutput("t1_ack1_consume", c, 1'b1);
      checkOutput("t1_led_start", txStart, 1'b1);
      checkOutput("t1_led_byte", txData, 8'h05);
      tick();
      pulseTxDone();
      rxByte(8'hFA, c);
      checkOutput("t1_ack2_consume", c, 1'b1);
      busRead(REG0, rd);
      checkOutput("t1_done", rd, 8'h40);
      busRead(REG1, rd);
      checkOutput("t1_shadow", rd, 8'h05);
      checkOutput("t1_irq_off", irqOut, 1'b0);

      $display("[TB] interrupt enable and status clear");
      applyStimulus(REG0, 8'h01);
      checkOutput("t2_irq_on", irqOut, 1'b1);
      applyStimulus(REG0, 8'h03);
      checkOutput("t2_irq_cleared", irqOut, 1'b0);
      busRead(REG0, rd);
      checkOutput("t2_reg0", rd, 8'h01);
      applyStimulus(REG0, 8'h00);

      $display("[TB] resend in LED phase");
      applyStimulus(REG1, 8'h06);
      tick();
      pulseTxDone();
      rxByte(8'hFA, c);
      tick();
      pulseTxDone();
      base = txCount;
      tbase = edCount;
      rxByte(8'hFE, c);
      checkOutput("t3_resend_consume", c, 1'b1);
      checkOutput("t3_resend_start", txStart, 1'b1);
      checkOutput("t3_resend_byte", txData, 8'h06);
      tick();
      pulseTxDone();
      rxByte(8'hFA, c);
      checkOutput("t3_extra_tx", txCount - base, 1);
      checkOutput("t3_no_cmd_resent", edCount - tbase, 0);
      busRead(REG1, rd);
      checkOutput("t3_shadow", rd, 8'h06);
      busRead(REG0, rd);
      checkOutput("t3_done", rd, 8'h40);

      $display("[TB] timeout with retry exhaustion");
      base = txCount;
      tbase = txTimes.size();
      applyStimulus(REG1, 8'h03);
      finished = 1'b0;
      for (int i = 0; i < 6 * (TMO + 1); i++) begin
         busRead(REG0, rd);
         if (!rd[7]) begin
            finished = 1'b1;
            break;
         end
         tick();
      end
      checkOutput("t4_terminated", finished, 1'b1);
      checkOutput("t4_tx_count", txCount - base, 4);
      checkOutput("t4_last_byte", lastTxData, 8'hED);
      if (txTimes.size() - tbase == 4) begin
         for (int k = 1; k < 4; k++) begin
            checkOutput("t4_spacing", txTimes[tbase + k] - txTimes[tbase + k - 1], TMO + 1);
         end
      end
      busRead(REG0, rd);
      checkOutput("t4_err", rd, 8'h20);
      busRead(REG1, rd);
      checkOutput("t4_shadow_kept", rd, 8'h06);

      $display("[TB] scan code ignored, pending request");
      applyStimulus(REG1, 8'h05);
      tick();
      pulseTxDone();
      rxByte(8'h1C, c);
      checkOutput("t5_scan_not_consumed", c, 1'b0);
      busRead(REG0, rd);
      checkOutput("t5_still_busy", rd, 8'h80);
      rxByte(8'hFA, c);
      checkOutput("t5_ack1_consume", c, 1'b1);
      checkOutput("t5_led_byte", txData, 8'h05);
      tick();
      pulseTxDone();
      applyStimulus(REG1, 8'h02);
      busRead(REG0, rd);
      checkOutput("t5_pend", rd, 8'h88);
      rxByte(8'hFA, c);
      busRead(REG0, rd);
      checkOutput("t5_done_pend", rd, 8'h48);
      tick();
      checkOutput("t5_second_cmd", txStart, 1'b1);
      checkOutput("t5_second_cmd_byte", txData, 8'hED);
      tick();
      pulseTxDone();
      rxByte(8'hFA, c);
      checkOutput("t5_second_led", txStart, 1'b1);
      checkOutput("t5_second_led_byte", txData, 8'h02);
      tick();
      pulseTxDone();

      $display("[TB] reset in WAIT_ACK2");
      rxData  = 8'hFA;
      rxValid = 1'b1;
      rst     = 1'b1;
      #1;
      checkOutput("t6_rst_consume", rxConsume, 1'b0);
      checkOutput("t6_rst_start", txStart, 1'b0);
      checkOutput("t6_rst_irq", irqOut, 1'b0);
      busRead(REG0, rd);
      checkOutput("t6_rst_reg0", rd, 8'h00);
      busRead(REG1, rd);
      checkOutput("t6_rst_shadow", rd, 8'h00);
      rxValid = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      $display("[TB] abort mid-sequence");
      applyStimulus(REG1, 8'h07);
      tick();
      pulseTxDone();
      applyStimulus(REG1, 8'h01);
      applyStimulus(REG0, 8'h04);
      base = txCount;
      busRead(REG0, rd);
      checkOutput("t7_abort_reg0", rd, 8'h00);
      repeat (5) tick();
      checkOutput("t7_no_tx", txCount - base, 0);
      busRead(REG0, rd);
      checkOutput("t7_idle", rd, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
